poly_reduce_buffer: RTL

- Downstream neighbour of polyvec_basemul_acc_mont.
- Consumes the accumulated coefficient-pair stream (dout_1/dout_2/out_index), applies the Kyber Barrett reduction to each coefficient and stores the result in a 2^DEPTH x 16 buffer.
- Once a full polynomial is held, it replays the pairs in index order to the next stage (invntt or tomont).
- Ping-pong is not provided: the buffer alternates FILL and DRAIN phases.

---
 rtl/poly_reduce_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/poly_reduce_buffer.sv
// rtl/poly_reduce_buffer.sv - Barrett-reducing coefficient-pair buffer with FILL/DRAIN phases
module poly_reduce_buffer #(
  parameter int DEPTH     = 8,
  parameter int KYBER_Q   = 3329,
  parameter int BARRETT_V = 20159
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [15:0]      din_1,
  input  logic [15:0]      din_2,
  input  logic [DEPTH-1:0] din_index,
  output logic             readin_ok,
  input  logic             readout,
  output logic [15:0]      dout_1,
  output logic [15:0]      dout_2,
  output logic [DEPTH-1:0] out_index,
  output logic             dout_valid,
  output logic             full,
  output logic             done
);

  localparam int PW    = DEPTH - 1;
  localparam int NPAIR = 1 << PW;

  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic signed [31:0] C_V    = BARRETT_V;
  localparam logic signed [31:0] C_Q    = KYBER_Q;
  localparam logic signed [31:0] C_HALF = 32'sd33554432;
  localparam logic [PW-1:0]      LAST_PAIR = {PW{1'b1}};

  logic [0:0]         r_state;
  logic               r_in_closed;
  logic [PW-1:0]      r_acc_cnt;
  logic [PW-1:0]      r_wr_cnt;
  logic [PW-1:0]      r_rd_cnt;

  logic               r_s1_valid;
  logic [PW-1:0]      r_s1_pair;
  logic signed [31:0] r_s1_p1;
  logic signed [31:0] r_s1_p2;
  logic [15:0]        r_s1_a1;
  logic [15:0]        r_s1_a2;

  logic [15:0]        r_mem_lo [NPAIR];
  logic [15:0]        r_mem_hi [NPAIR];

  logic [15:0]        r_dout_1;
  logic [15:0]        r_dout_2;
  logic [DEPTH-1:0]   r_out_index;
  logic               r_dout_valid;
  logic               r_done;

  logic               w_accept;
  logic               w_wr_en;
  logic               w_rd_req;
  logic signed [31:0] w_a1;
  logic signed [31:0] w_a2;
  logic [15:0]        w_r1;
  logic [15:0]        w_r2;
  logic               w_unused_lsb;

  // Second half of Barrett: round the product by 2^26, subtract t*q from the operand.
  function automatic logic [15:0] barrett_finish(input logic signed [31:0] p,
                                                 input logic [15:0] a);
    logic signed [31:0] t;
    logic signed [31:0] r;
    t = (p + C_HALF) >>> 26;
    r = $signed({{16{a[15]}}, a}) - t * C_Q;
    return r[15:0];
  endfunction

  assign readin_ok    = (r_state == S_FILL) && !r_in_closed;
  assign w_accept     = din_valid && readin_ok;
  assign w_wr_en      = r_s1_valid && (r_state == S_FILL);
  // The done cycle still shows full; block a second read of pair 0 there.
  assign w_rd_req     = readout && (r_state == S_DRAIN) && !r_done;
  assign w_a1         = $signed({{16{din_1[15]}}, din_1});
  assign w_a2         = $signed({{16{din_2[15]}}, din_2});
  assign w_r1         = barrett_finish(r_s1_p1, r_s1_a1);
  assign w_r2         = barrett_finish(r_s1_p2, r_s1_a2);
  assign w_unused_lsb = din_index[0];

  assign full       = (r_state == S_DRAIN);
  assign dout_1     = r_dout_1;
  assign dout_2     = r_dout_2;
  assign out_index  = r_out_index;
  assign dout_valid = r_dout_valid;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_lo[r_s1_pair] <= w_r1;
      r_mem_hi[r_s1_pair] <= w_r2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FILL;
      r_in_closed  <= 1'b0;
      r_acc_cnt    <= '0;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_pair    <= '0;
      r_s1_p1      <= '0;
      r_s1_p2      <= '0;
      r_s1_a1      <= '0;
      r_s1_a2      <= '0;
      r_dout_1     <= '0;
      r_dout_2     <= '0;
      r_out_index  <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_pair <= din_index[DEPTH-1:1];
        r_s1_p1   <= w_a1 * C_V;
        r_s1_p2   <= w_a2 * C_V;
        r_s1_a1   <= din_1;
        r_s1_a2   <= din_2;
        r_acc_cnt <= r_acc_cnt + 1'b1;
        if (r_acc_cnt == LAST_PAIR) r_in_closed <= 1'b1;
      end

      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (r_wr_cnt == LAST_PAIR) r_state <= S_DRAIN;
      end

      r_dout_valid <= w_rd_req;
      r_done       <= w_rd_req && (r_rd_cnt == LAST_PAIR);
      if (w_rd_req) begin
        r_dout_1    <= r_mem_lo[r_rd_cnt];
        r_dout_2    <= r_mem_hi[r_rd_cnt];
        r_out_index <= {r_rd_cnt, 1'b0};
        r_rd_cnt    <= r_rd_cnt + 1'b1;
      end

      if (r_done) begin
        r_state     <= S_FILL;
        r_in_closed <= 1'b0;
      end
    end
  end

endmodule
